// File: rtl/render_shape_setup_if.sv
// Pose-table write port of render_shape_setup: the game/CPU side is the master.
// A pose is written on the rising edge where cfg_valid && cfg_ready; cfg_ready is low only while a computation runs.
interface render_shape_setup_if #(
    parameter int N_SHAPES   = 7,
    parameter int INT_BITS   = 12,
    parameter int ANGLE_BITS = 6
);
    localparam int IDX_W = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1;

    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [IDX_W-1:0]      cfg_idx;
    logic [INT_BITS-1:0]   cfg_px;
    logic [INT_BITS-1:0]   cfg_py;
    logic [ANGLE_BITS-1:0] cfg_angle;
    logic [INT_BITS-1:0]   cfg_ty;
    logic [INT_BITS-1:0]   cfg_size;

    modport master (
        output cfg_valid, cfg_idx, cfg_px, cfg_py, cfg_angle, cfg_ty, cfg_size,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_px, cfg_py, cfg_angle, cfg_ty, cfg_size,
        output cfg_ready
    );
endinterface

// File: rtl/render_shape_setup.sv
// Per-frame parameter generator for the shape rasterisers: pose table in, double-buffered
// sin/cos/ix/iy bank out, computed during vblank with a single shared multiplier.
module render_shape_setup #(
    parameter int N_SHAPES       = 7,
    parameter int ANGLE_BITS     = 6,
    parameter int INT_BITS       = 12,
    parameter int FLOAT_BITS     = 24,
    parameter int FLOAT_DCM_BITS = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    render_shape_setup_if.slave            cfg,
    input  logic                           start,
    input  logic                           newframe,
    output logic                           busy,
    output logic                           done,
    output logic [N_SHAPES*INT_BITS-1:0]   out_ty,
    output logic [N_SHAPES*INT_BITS-1:0]   out_size,
    output logic [N_SHAPES*FLOAT_BITS-1:0] out_sin,
    output logic [N_SHAPES*FLOAT_BITS-1:0] out_cos,
    output logic [N_SHAPES*FLOAT_BITS-1:0] out_ix,
    output logic [N_SHAPES*FLOAT_BITS-1:0] out_iy,
    output logic [2:0]                     dbg_state
);
    localparam int IDX_W  = (N_SHAPES > 1) ? $clog2(N_SHAPES) : 1;
    localparam int ONE    = 1 << FLOAT_DCM_BITS;
    localparam int QW     = ANGLE_BITS - 2;
    localparam int QMAX   = 1 << QW;
    localparam int PROD_W = INT_BITS + 1 + FLOAT_BITS;
    localparam int ACC_W  = PROD_W + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SHAPES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL0  = 3'd2,
        S_MUL1  = 3'd3,
        S_MUL2  = 3'd4,
        S_MUL3  = 3'd5,
        S_WRITE = 3'd6
    } state_t;

    state_t state_q, state_d;
    logic   load_en, last_write, start_acc, swap;

    logic [IDX_W-1:0] k_q;
    logic             pending_valid, done_q;

    logic [INT_BITS-1:0]   sh_px    [N_SHAPES];
    logic [INT_BITS-1:0]   sh_py    [N_SHAPES];
    logic [ANGLE_BITS-1:0] sh_angle [N_SHAPES];
    logic [INT_BITS-1:0]   sh_ty    [N_SHAPES];
    logic [INT_BITS-1:0]   sh_size  [N_SHAPES];

    logic [INT_BITS-1:0]   pend_ty   [N_SHAPES];
    logic [INT_BITS-1:0]   pend_size [N_SHAPES];
    logic [FLOAT_BITS-1:0] pend_sin  [N_SHAPES];
    logic [FLOAT_BITS-1:0] pend_cos  [N_SHAPES];
    logic [FLOAT_BITS-1:0] pend_ix   [N_SHAPES];
    logic [FLOAT_BITS-1:0] pend_iy   [N_SHAPES];

    logic [INT_BITS-1:0]   act_ty   [N_SHAPES];
    logic [INT_BITS-1:0]   act_size [N_SHAPES];
    logic [FLOAT_BITS-1:0] act_sin  [N_SHAPES];
    logic [FLOAT_BITS-1:0] act_cos  [N_SHAPES];
    logic [FLOAT_BITS-1:0] act_ix   [N_SHAPES];
    logic [FLOAT_BITS-1:0] act_iy   [N_SHAPES];

    logic [INT_BITS-1:0]   cur_px, cur_py, cur_ty, cur_size;
    logic [FLOAT_BITS-1:0] cur_sin, cur_cos;
    logic signed [ACC_W-1:0] acc_x, acc_y;

    // Quarter-wave table round(sin(k*2pi/64) * 4096); entries assume 6 angle bits and 12 fraction bits.
    function automatic logic [FLOAT_BITS-1:0] quarter(input logic [QW:0] i);
        int v;
        case (int'(i))
            0:       v = 0;
            1:       v = 401;
            2:       v = 799;
            3:       v = 1189;
            4:       v = 1567;
            5:       v = 1931;
            6:       v = 2276;
            7:       v = 2598;
            8:       v = 2896;
            9:       v = 3166;
            10:      v = 3406;
            11:      v = 3612;
            12:      v = 3784;
            13:      v = 3920;
            14:      v = 4017;
            15:      v = 4076;
            default: v = ONE;
        endcase
        return FLOAT_BITS'(v);
    endfunction

    // ---------------- FSM ----------------
    assign busy           = (state_q != S_IDLE);
    assign cfg.cfg_ready  = !busy;
    assign done           = done_q;
    assign dbg_state      = state_q;
    assign start_acc      = (state_q == S_IDLE) && start;
    // A bank finished this cycle is not swappable until done has dropped.
    assign swap           = newframe && pending_valid && !done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // The IDLE cycle that accepts start doubles as the LOAD of shape 0.
    always_comb begin
        state_d    = state_q;
        load_en    = 1'b0;
        last_write = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = S_MUL0;
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                state_d = S_MUL0;
            end
            S_MUL0:  state_d = S_MUL1;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_MUL3;
            S_MUL3:  state_d = S_WRITE;
            S_WRITE: begin
                if (k_q == LAST) begin
                    last_write = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- trig lookup ----------------
    logic [ANGLE_BITS-1:0] ang;
    logic [1:0]            quad;
    logic [QW:0]           fine;
    logic [FLOAT_BITS-1:0] q_lo, q_hi, lut_sin, lut_cos;

    assign ang  = sh_angle[k_q];
    assign quad = ang[ANGLE_BITS-1 -: 2];
    assign fine = {1'b0, ang[QW-1:0]};
    assign q_lo = quarter(fine);
    assign q_hi = quarter((QW+1)'(QMAX) - fine);

    always_comb begin
        lut_sin = q_lo;
        lut_cos = q_hi;
        case (quad)
            2'd0: begin lut_sin = q_lo;  lut_cos = q_hi;  end
            2'd1: begin lut_sin = q_hi;  lut_cos = -q_lo; end
            2'd2: begin lut_sin = -q_lo; lut_cos = -q_hi; end
            default: begin lut_sin = -q_hi; lut_cos = q_lo; end
        endcase
    end

    // ---------------- shared multiplier ----------------
    logic [INT_BITS-1:0]     mul_a;
    logic [FLOAT_BITS-1:0]   mul_b;
    logic signed [PROD_W-1:0] a_ext, b_ext, prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign mul_a    = (state_q == S_MUL0 || state_q == S_MUL2) ? cur_px  : cur_py;
    assign mul_b    = (state_q == S_MUL0 || state_q == S_MUL3) ? cur_cos : cur_sin;
    assign a_ext    = {{(FLOAT_BITS+1){1'b0}}, mul_a};
    assign b_ext    = {{(INT_BITS+1){mul_b[FLOAT_BITS-1]}}, mul_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {prod[PROD_W-1], prod};

    logic unused_acc_hi;
    assign unused_acc_hi = ^{acc_x[ACC_W-1:FLOAT_BITS], acc_y[ACC_W-1:FLOAT_BITS]};

    // ---------------- pose table ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SHAPES; i++) begin
                sh_px[i] <= '0; sh_py[i] <= '0; sh_angle[i] <= '0;
                sh_ty[i] <= '0; sh_size[i] <= '0;
            end
        end else if (cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_idx) < N_SHAPES)) begin
            sh_px[cfg.cfg_idx]    <= cfg.cfg_px;
            sh_py[cfg.cfg_idx]    <= cfg.cfg_py;
            sh_angle[cfg.cfg_idx] <= cfg.cfg_angle;
            sh_ty[cfg.cfg_idx]    <= cfg.cfg_ty;
            sh_size[cfg.cfg_idx]  <= cfg.cfg_size;
        end
    end

    // ---------------- per-shape datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0; cur_px <= '0; cur_py <= '0; cur_ty <= '0; cur_size <= '0;
            cur_sin <= '0; cur_cos <= '0; acc_x <= '0; acc_y <= '0;
            done_q <= 1'b0; pending_valid <= 1'b0;
        end else begin
            done_q <= last_write;
            if (last_write)                pending_valid <= 1'b1;
            else if (start_acc || swap)    pending_valid <= 1'b0;

            if (load_en) begin
                cur_px   <= sh_px[k_q];
                cur_py   <= sh_py[k_q];
                cur_ty   <= sh_ty[k_q];
                cur_size <= sh_size[k_q];
                cur_sin  <= lut_sin;
                cur_cos  <= lut_cos;
            end
            case (state_q)
                S_MUL0:  acc_x <= -prod_ext;
                S_MUL1:  acc_x <= acc_x + prod_ext;
                S_MUL2:  acc_y <= -prod_ext;
                S_MUL3:  acc_y <= acc_y - prod_ext;
                S_WRITE: k_q   <= last_write ? '0 : k_q + 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- pending / active banks ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SHAPES; i++) begin
                pend_ty[i] <= '0; pend_size[i] <= '0; pend_sin[i] <= '0;
                pend_cos[i] <= '0; pend_ix[i] <= '0; pend_iy[i] <= '0;
                act_ty[i] <= '0; act_size[i] <= '0; act_sin[i] <= '0;
                act_cos[i] <= '0; act_ix[i] <= '0; act_iy[i] <= '0;
            end
        end else begin
            if (state_q == S_WRITE) begin
                pend_ty[k_q]   <= cur_ty;
                pend_size[k_q] <= cur_size;
                pend_sin[k_q]  <= cur_sin;
                pend_cos[k_q]  <= cur_cos;
                pend_ix[k_q]   <= acc_x[FLOAT_BITS-1:0];
                pend_iy[k_q]   <= acc_y[FLOAT_BITS-1:0];
            end
            if (swap) begin
                for (int i = 0; i < N_SHAPES; i++) begin
                    act_ty[i] <= pend_ty[i]; act_size[i] <= pend_size[i];
                    act_sin[i] <= pend_sin[i]; act_cos[i] <= pend_cos[i];
                    act_ix[i] <= pend_ix[i]; act_iy[i] <= pend_iy[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_SHAPES; g++) begin : g_out
        assign out_ty[g*INT_BITS +: INT_BITS]       = act_ty[g];
        assign out_size[g*INT_BITS +: INT_BITS]     = act_size[g];
        assign out_sin[g*FLOAT_BITS +: FLOAT_BITS]  = act_sin[g];
        assign out_cos[g*FLOAT_BITS +: FLOAT_BITS]  = act_cos[g];
        assign out_ix[g*FLOAT_BITS +: FLOAT_BITS]   = act_ix[g];
        assign out_iy[g*FLOAT_BITS +: FLOAT_BITS]   = act_iy[g];
    end
endmodule
